// File: rtl/scan_coord_pkg.sv
// Shared constants, lane identifiers and config payload types for the scan
// coordinate stepper. The stepper produces affine per-pixel coordinates for
// the vectoring CORDIC length stage.
package scan_coord_pkg;

    // Coordinate and step width, in two's complement.
    localparam int unsigned W               = 16;
    // Width of the shadow config address bus.
    localparam int unsigned CFG_AW          = 4;
    // Number of coordinate lanes.
    localparam int unsigned NLANE           = 4;
    // Field offsets within a lane's config triplet.
    localparam int unsigned CFG_ORG         = 0;
    localparam int unsigned CFG_DH          = 1;
    localparam int unsigned CFG_DV          = 2;
    localparam int unsigned CFG_LANE_STRIDE = 3;
    // Number of implemented config registers. Addresses at or above NREG are ignored.
    localparam int unsigned NREG            = 12;

    // Lane order matches the CORDIC inputs xin/yin/x2in/y2in.
    typedef enum logic [1:0] {
        LANE_X  = 2'd0,
        LANE_Y  = 2'd1,
        LANE_X2 = 2'd2,
        LANE_Y2 = 2'd3
    } lane_e;

    // One config bank of a lane: origin, per-pixel step and per-line step.
    typedef struct packed {
        logic [W-1:0] org;
        logic [W-1:0] dh;
        logic [W-1:0] dv;
    } lane_cfg_t;

    // Flat register index of one field of one lane.
    function automatic logic [CFG_AW-1:0] cfg_index(input lane_e lane, input int unsigned field);
        return CFG_AW'(int'(lane) * int'(CFG_LANE_STRIDE) + int'(field));
    endfunction

endpackage : scan_coord_pkg

// File: rtl/coord_lane_acc.sv
// One coordinate lane: a double-buffered {ORG,DH,DV} config and the
// line-origin / current-pixel accumulators that step the coordinate.
//
// Ports
//   clk, reset   pixel clock, synchronous active-high reset
//   we_org/dh/dv decoded shadow write enables for this lane
//   wdata        shadow write data
//   frame_start  copy shadow to active, reload origin
//   line_start   begin a line (first line keeps the origin, later lines add DV)
//   pix_en       advance by DH
//   first_line   set between frame_start and the first line_start
//   cur          registered lane coordinate for the current pixel
module coord_lane_acc
    import scan_coord_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         we_org,
    input  logic         we_dh,
    input  logic         we_dv,
    input  logic [W-1:0] wdata,
    input  logic         frame_start,
    input  logic         line_start,
    input  logic         pix_en,
    input  logic         first_line,
    output logic [W-1:0] cur
);

    lane_cfg_t    shadow;
    lane_cfg_t    active;
    logic [W-1:0] row_acc;

    // Adders wrap mod 2^W; wrapping is intended for repeating patterns.
    logic [W-1:0] row_next;
    logic [W-1:0] pix_next;

    always_comb begin
        row_next = row_acc + active.dv;
        pix_next = cur + active.dh;
    end

    // Shadow writes are independent of the beam events. On a frame_start that
    // coincides with a write, active picks up the pre-write shadow value.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            row_acc <= '0;
            cur     <= '0;
        end else begin
            if (we_org) shadow.org <= wdata;
            if (we_dh)  shadow.dh  <= wdata;
            if (we_dv)  shadow.dv  <= wdata;

            if (frame_start) begin
                active  <= shadow;
                row_acc <= shadow.org;
                cur     <= shadow.org;
            end else if (line_start) begin
                // The first line of a frame starts at the origin itself.
                if (first_line) begin
                    cur <= row_acc;
                end else begin
                    row_acc <= row_next;
                    cur     <= row_next;
                end
            end else if (pix_en) begin
                cur <= pix_next;
            end
        end
    end

endmodule : coord_lane_acc

// File: rtl/scan_coord_stepper.sv
// Per-pixel affine coordinate generator feeding the 2-step vectoring CORDIC.
// Four lanes (x, y, x2, y2) each compute ORG + k*DH + j*DV with adders only,
// valid in the same cycle as pix_en. Config is written into a shadow bank
// and becomes active at frame_start so a frame never tears.
//
// Ports
//   clk          pixel clock
//   reset        synchronous active-high reset
//   cfg_we       shadow config write strobe
//   cfg_addr     shadow register index: lane*3 + {ORG,DH,DV}; 12..15 ignored
//   cfg_data     shadow write data
//   frame_start  pulse before the first line of a frame
//   line_start   pulse one cycle before the first pix_en of a line
//   pix_en       active-pixel strobe
//   x_out..y2_out lane coordinates (registered)
//   cfg_pending  shadow written since the last frame_start (registered)
module scan_coord_stepper
    import scan_coord_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CFG_AW-1:0] cfg_addr,
    input  logic [W-1:0]      cfg_data,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              pix_en,
    output logic [W-1:0]      x_out,
    output logic [W-1:0]      y_out,
    output logic [W-1:0]      x2_out,
    output logic [W-1:0]      y2_out,
    output logic              cfg_pending
);

    logic             first_line;
    logic             cfg_hit;
    logic [NLANE-1:0] we_org;
    logic [NLANE-1:0] we_dh;
    logic [NLANE-1:0] we_dv;
    logic [W-1:0]     lane_cur [NLANE];

    // Only writes to implemented registers count as config activity.
    always_comb begin
        cfg_hit = cfg_we && (cfg_addr < CFG_AW'(NREG));
    end

    // Address decode into per-lane field write enables.
    for (genvar l = 0; l < int'(NLANE); l++) begin : g_lane
        localparam lane_e LANE = lane_e'(l);

        always_comb begin
            we_org[l] = cfg_hit && (cfg_addr == cfg_index(LANE, CFG_ORG));
            we_dh[l]  = cfg_hit && (cfg_addr == cfg_index(LANE, CFG_DH));
            we_dv[l]  = cfg_hit && (cfg_addr == cfg_index(LANE, CFG_DV));
        end

        coord_lane_acc u_lane (
            .clk         (clk),
            .reset       (reset),
            .we_org      (we_org[l]),
            .we_dh       (we_dh[l]),
            .we_dv       (we_dv[l]),
            .wdata       (cfg_data),
            .frame_start (frame_start),
            .line_start  (line_start),
            .pix_en      (pix_en),
            .first_line  (first_line),
            .cur         (lane_cur[l])
        );
    end

    // First-line flag: a line_start coinciding with frame_start is ignored,
    // so the flag stays set until a standalone line_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_line <= 1'b1;
        end else if (frame_start) begin
            first_line <= 1'b1;
        end else if (line_start) begin
            first_line <= 1'b0;
        end
    end

    // Pending flag: cleared by frame_start unless a write lands in that same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_pending <= 1'b0;
        end else if (frame_start) begin
            cfg_pending <= cfg_hit;
        end else if (cfg_hit) begin
            cfg_pending <= 1'b1;
        end
    end

    always_comb begin
        x_out  = lane_cur[LANE_X];
        y_out  = lane_cur[LANE_Y];
        x2_out = lane_cur[LANE_X2];
        y2_out = lane_cur[LANE_Y2];
    end

endmodule : scan_coord_stepper

// File: tb/tb_scan_coord_stepper.sv
// Directed bench for scan_coord_stepper. Stimulus pushes the expected lane
// values for each pixel (or explicit probe) cycle into a queue; a monitor
// samples on the falling edge whenever pix_en or probe is high and compares.
module tb_scan_coord_stepper;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        frame_start;
    logic        line_start;
    logic        pix_en;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic [15:0] x2_out;
    logic [15:0] y2_out;
    logic        cfg_pending;
    logic        probe;

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] x2;
        logic [15:0] y2;
        logic        pend;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   id_ctr = 0;

    scan_coord_stepper dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .frame_start (frame_start),
        .line_start  (line_start),
        .pix_en      (pix_en),
        .x_out       (x_out),
        .y_out       (y_out),
        .x2_out      (x2_out),
        .y2_out      (y2_out),
        .cfg_pending (cfg_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per sampled cycle.
    always @(negedge clk) begin
        if (pix_en || probe) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_sample: got x=%h y=%h x2=%h y2=%h pend=%b, no expectation queued",
                         x_out, y_out, x2_out, y2_out, cfg_pending);
            end else begin
                e = exp_q.pop_front();
                if ({x_out, y_out, x2_out, y2_out, cfg_pending} !== {e.x, e.y, e.x2, e.y2, e.pend}) begin
                    n_err++;
                    $display("FAIL vec%0d: got x=%h y=%h x2=%h y2=%h pend=%b, want x=%h y=%h x2=%h y2=%h pend=%b",
                             e.id, x_out, y_out, x2_out, y2_out, cfg_pending,
                             e.x, e.y, e.x2, e.y2, e.pend);
                end
            end
        end
    end

    // Apply one cycle of inputs, then return just after the capturing edge.
    task automatic drive(input logic rs, input logic fs, input logic ls, input logic pe,
                         input logic pr, input logic we, input logic [3:0] a,
                         input logic [15:0] d);
        reset       = rs;
        frame_start = fs;
        line_start  = ls;
        pix_en      = pe;
        probe       = pr;
        cfg_we      = we;
        cfg_addr    = a;
        cfg_data    = d;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        pix_en      = 1'b0;
        probe       = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = 4'h0;
        cfg_data    = 16'h0000;
    endtask

    task automatic expect_out(input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] x2, input logic [15:0] y2, input logic p);
        exp_q.push_back({16'(id_ctr), x, y, x2, y2, p});
        id_ctr++;
    endtask

    task automatic pix(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] x2, input logic [15:0] y2, input logic p);
        expect_out(x, y, x2, y2, p);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
    endtask

    task automatic chk(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] x2, input logic [15:0] y2, input logic p);
        expect_out(x, y, x2, y2, p);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0000);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic fs_pulse();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
    endtask

    task automatic ls_pulse();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; pix_en = 1'b0;
        probe = 1'b0; cfg_we = 1'b0; cfg_addr = 4'h0; cfg_data = 16'h0000;

        // 1: reset state and an unconfigured frame
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        chk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        wr(4'hF, 16'hABCD);                    // unimplemented address
        chk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        fs_pulse();
        ls_pulse();
        for (int i = 0; i < 3; i++) pix(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        // 2: x lane stepping across lines
        wr(4'd0, 16'h0100);
        wr(4'd1, 16'h0002);
        wr(4'd2, 16'h0010);
        chk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        fs_pulse();
        chk(16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        ls_pulse();
        pix(16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        pix(16'h0102, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        pix(16'h0104, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        pix(16'h0106, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        chk(16'h0108, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        ls_pulse();
        chk(16'h0110, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        pix(16'h0110, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        pix(16'h0112, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        ls_pulse();
        chk(16'h0120, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        // 3: mid-line DH write stays in shadow until the next frame
        expect_out(16'h0120, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0005);
        pix(16'h0122, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        pix(16'h0124, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        ls_pulse();
        pix(16'h0130, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        fs_pulse();
        chk(16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        ls_pulse();
        pix(16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        pix(16'h0105, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        pix(16'h010A, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        // 4: wrap-around on y (DH) and x2 (DV), plus a plain y2 lane
        wr(4'd3,  16'h7FFF);
        wr(4'd4,  16'h0001);
        wr(4'd5,  16'hFFFF);
        wr(4'd8,  16'hFFFF);
        wr(4'd9,  16'h1234);
        wr(4'd10, 16'h0001);
        wr(4'd11, 16'h0100);
        chk(16'h010F, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        fs_pulse();
        chk(16'h0100, 16'h7FFF, 16'h0000, 16'h1234, 1'b0);
        ls_pulse();
        pix(16'h0100, 16'h7FFF, 16'h0000, 16'h1234, 1'b0);
        pix(16'h0105, 16'h8000, 16'h0000, 16'h1235, 1'b0);
        ls_pulse();
        pix(16'h0110, 16'h7FFE, 16'hFFFF, 16'h1334, 1'b0);
        ls_pulse();
        pix(16'h0120, 16'h7FFD, 16'hFFFE, 16'h1434, 1'b0);

        // 5a: frame_start with line_start -> next line_start yields ORG, no DV
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        chk(16'h0100, 16'h7FFF, 16'h0000, 16'h1234, 1'b0);
        ls_pulse();
        pix(16'h0100, 16'h7FFF, 16'h0000, 16'h1234, 1'b0);
        pix(16'h0105, 16'h8000, 16'h0000, 16'h1235, 1'b0);
        // 5b: line_start with pix_en -> line advances, no DH added
        expect_out(16'h010A, 16'h8001, 16'h0000, 16'h1236, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        pix(16'h0110, 16'h7FFE, 16'hFFFF, 16'h1334, 1'b0);
        // 5c: frame_start with cfg_we -> new value lands in shadow only
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0200);
        chk(16'h0100, 16'h7FFF, 16'h0000, 16'h1234, 1'b1);
        ls_pulse();
        pix(16'h0100, 16'h7FFF, 16'h0000, 16'h1234, 1'b1);
        fs_pulse();
        chk(16'h0200, 16'h7FFF, 16'h0000, 16'h1234, 1'b0);

        // 6: reset mid-line clears everything including shadow and pending
        ls_pulse();
        pix(16'h0200, 16'h7FFF, 16'h0000, 16'h1234, 1'b0);
        pix(16'h0205, 16'h8000, 16'h0000, 16'h1235, 1'b0);
        wr(4'd0, 16'h0055);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        chk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        ls_pulse();
        pix(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        fs_pulse();
        chk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        ls_pulse();
        pix(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        pix(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        // Drain: every queued expectation must have been consumed.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_scan_coord_stepper
